// File: rtl/pa_fpu.sv
// Shared FPU definitions: operation codes, register map and the sequencer/access-engine
// state types used by the bus sequencer.
package pa_fpu;

    typedef enum logic [7:0] {
        op_add  = 8'h00,
        op_sub  = 8'h01,
        op_mul  = 8'h02,
        op_div  = 8'h03,
        op_sqrt = 8'h04,
        op_abs  = 8'h05,
        op_neg  = 8'h06
    } e_fpu_operations;

    localparam logic [3:0] FPU_REG_A0    = 4'h0;
    localparam logic [3:0] FPU_REG_A1    = 4'h1;
    localparam logic [3:0] FPU_REG_A2    = 4'h2;
    localparam logic [3:0] FPU_REG_A3    = 4'h3;
    localparam logic [3:0] FPU_REG_B0    = 4'h4;
    localparam logic [3:0] FPU_REG_B1    = 4'h5;
    localparam logic [3:0] FPU_REG_B2    = 4'h6;
    localparam logic [3:0] FPU_REG_B3    = 4'h7;
    localparam logic [3:0] FPU_REG_OP    = 4'h8;
    localparam logic [3:0] FPU_REG_START = 4'h9;
    localparam logic [3:0] FPU_REG_RES0  = 4'h9;
    localparam logic [3:0] FPU_REG_RES1  = 4'hA;
    localparam logic [3:0] FPU_REG_RES2  = 4'hB;
    localparam logic [3:0] FPU_REG_RES3  = 4'hC;

    typedef enum logic [2:0] {
        IDLE, CLEAR, WR_OPS, WAIT_END, RD_RES, ACK, RESP
    } e_seq_state;

    typedef enum logic [1:0] {
        PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD
    } e_acc_phase;

    // Write-burst slot to register address; unary ops skip the B block.
    function automatic logic [3:0] wr_addr(input logic [3:0] idx, input logic use_b);
        return (use_b || idx < 4'd4) ? idx : idx + 4'd4;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fpu_bus_access.sv
// Single byte access on the FPU register port: SETUP, STROBE (STROBE_CYCLES), HOLD.
// A new request is taken in IDLE or in HOLD so bursts run back to back.
module fpu_bus_access
    import pa_fpu::*;
#(
    parameter int STROBE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       req,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    input  logic       is_read,
    input  logic       keep_cs,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       bus_cs,
    output logic       bus_rd,
    output logic       bus_wr,
    output logic [3:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata
);

    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SCW-1:0] STB_LAST = SCW'(STROBE_CYCLES - 1);

    e_acc_phase     phase_q, phase_d;
    logic [SCW-1:0] stb_q, stb_d;
    logic           is_read_q, is_read_d;
    logic           cs_q, cs_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [3:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           accept;

    assign ready  = (phase_q == PH_IDLE) || (phase_q == PH_HOLD);
    assign done   = (phase_q == PH_HOLD);
    assign accept = req && ready;

    always_comb begin
        phase_d   = phase_q;
        stb_d     = stb_q;
        is_read_d = is_read_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (phase_q)
            PH_IDLE, PH_HOLD: begin
                if (accept) begin
                    phase_d   = PH_SETUP;
                    addr_d    = addr;
                    is_read_d = is_read;
                    wdata_d   = is_read ? 8'h00 : wdata;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_SETUP: begin
                phase_d = PH_STROBE;
                stb_d   = '0;
            end
            PH_STROBE: begin
                // Read data is taken on the last strobe-low clock.
                if (stb_q == STB_LAST) begin
                    phase_d = PH_HOLD;
                    if (is_read_q) rdata_d = bus_rdata;
                end else begin
                    stb_d = stb_q + 1'b1;
                end
            end
            default: phase_d = PH_IDLE;
        endcase

        if (phase_d != PH_IDLE) cs_d = 1'b0;
        else                    cs_d = keep_cs ? cs_q : 1'b1;
        rd_d = !((phase_d == PH_STROBE) && is_read_d);
        wr_d = !((phase_d == PH_STROBE) && !is_read_d);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            phase_q   <= PH_IDLE;
            stb_q     <= '0;
            is_read_q <= 1'b0;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            addr_q    <= 4'h0;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            phase_q   <= phase_d;
            stb_q     <= stb_d;
            is_read_q <= is_read_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign bus_cs    = cs_q;
    assign bus_rd    = rd_q;
    assign bus_wr    = wr_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: rtl/fpu_bus_sequencer.sv
// Upstream master for the byte-wide FPU register port: takes one command, runs the full
// write/start/wait/read/ack protocol and returns the 32-bit result on a valid/ready port.
module fpu_bus_sequencer
    import pa_fpu::*;
#(
    parameter int STROBE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int TCW            = 16
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  e_fpu_operations cmd_op,
    input  logic [31:0]     cmd_a,
    input  logic [31:0]     cmd_b,
    input  logic            cmd_use_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_result,
    output logic            rsp_timeout,
    output logic [7:0]      fpu_databus_out,
    input  logic [7:0]      fpu_databus_in,
    output logic [3:0]      fpu_addr,
    output logic            fpu_cs,
    output logic            fpu_rd,
    output logic            fpu_wr,
    output logic            fpu_end_ack,
    input  logic            fpu_cmd_end,
    input  logic            fpu_busy,
    output logic            seq_busy
);

    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

    e_seq_state      state_q, state_d;
    e_fpu_operations op_q, op_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic            use_b_q, use_b_d;
    logic [3:0]      idx_q, idx_d;
    logic [TCW-1:0]  tmo_q, tmo_d;
    logic [31:0]     result_q, result_d;
    logic            timeout_q, timeout_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            end_ack_q, end_ack_d;

    logic            acc_req, acc_is_read, acc_keep_cs;
    logic [3:0]      acc_addr;
    logic [7:0]      acc_wdata;
    logic            acc_ready, acc_done, acc_accept;
    logic [7:0]      acc_rdata;
    logic [3:0]      n_wr;
    logic [3:0]      w_addr;
    logic            capture;
    logic            unused_fpu_busy;

    assign unused_fpu_busy = fpu_busy;
    assign n_wr       = use_b_q ? 4'd10 : 4'd6;
    assign w_addr     = wr_addr(idx_q, use_b_q);
    assign capture    = (state_q == IDLE) && cmd_valid;
    assign acc_accept = acc_req && acc_ready;

    // The next access of a burst is presented while the current one is in HOLD.
    always_comb begin
        acc_req     = 1'b0;
        acc_addr    = 4'h0;
        acc_wdata   = 8'h00;
        acc_is_read = 1'b0;
        acc_keep_cs = 1'b0;
        case (state_q)
            WR_OPS: begin
                acc_req     = idx_q < n_wr;
                acc_addr    = w_addr;
                acc_keep_cs = acc_req;
                if (w_addr < FPU_REG_B0)       acc_wdata = byte_of(a_q, w_addr[1:0]);
                else if (w_addr < FPU_REG_OP)  acc_wdata = byte_of(b_q, w_addr[1:0]);
                else if (w_addr == FPU_REG_OP) acc_wdata = op_q;
                else                           acc_wdata = 8'h00;
            end
            RD_RES: begin
                acc_req     = idx_q < 4'd4;
                acc_addr    = FPU_REG_RES0 + idx_q;
                acc_is_read = 1'b1;
                acc_keep_cs = acc_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        end_ack_d = end_ack_q;
        op_d      = capture ? cmd_op : op_q;
        a_d       = capture ? cmd_a : a_q;
        b_d       = capture ? cmd_b : b_q;
        use_b_d   = capture ? cmd_use_b : use_b_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    idx_d     = 4'd0;
                    result_d  = 32'h0;
                    timeout_d = 1'b0;
                    // A completion still pending from earlier must be flushed first.
                    if (fpu_cmd_end) begin
                        state_d   = CLEAR;
                        end_ack_d = 1'b1;
                    end else begin
                        state_d = WR_OPS;
                    end
                end
            end
            CLEAR: begin
                if (!fpu_cmd_end) begin
                    end_ack_d = 1'b0;
                    state_d   = WR_OPS;
                end
            end
            WR_OPS: begin
                if (acc_accept) idx_d = idx_q + 4'd1;
                if (acc_done && idx_q == n_wr) begin
                    state_d = WAIT_END;
                    tmo_d   = '0;
                end
            end
            WAIT_END: begin
                tmo_d = tmo_q + 1'b1;
                if (fpu_cmd_end) begin
                    state_d = RD_RES;
                    idx_d   = 4'd0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = RESP;
                    timeout_d = 1'b1;
                    result_d  = 32'h0;
                end
            end
            RD_RES: begin
                if (acc_accept) idx_d = idx_q + 4'd1;
                if (acc_done) result_d = {acc_rdata, result_q[31:8]};
                if (acc_done && idx_q == 4'd4) begin
                    state_d   = ACK;
                    end_ack_d = 1'b1;
                end
            end
            ACK: begin
                if (!fpu_cmd_end) begin
                    end_ack_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            tmo_q       <= '0;
            result_q    <= 32'h0;
            timeout_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            end_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            end_ack_q   <= end_ack_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        a_q     <= a_d;
        b_q     <= b_d;
        use_b_q <= use_b_d;
    end

    fpu_bus_access #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_access (
        .clk      (clk),
        .arst     (arst),
        .req      (acc_req),
        .addr     (acc_addr),
        .wdata    (acc_wdata),
        .is_read  (acc_is_read),
        .keep_cs  (acc_keep_cs),
        .ready    (acc_ready),
        .done     (acc_done),
        .rdata    (acc_rdata),
        .bus_cs   (fpu_cs),
        .bus_rd   (fpu_rd),
        .bus_wr   (fpu_wr),
        .bus_addr (fpu_addr),
        .bus_wdata(fpu_databus_out),
        .bus_rdata(fpu_databus_in)
    );

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = result_q;
    assign rsp_timeout = timeout_q;
    assign fpu_end_ack = end_ack_q;
    assign seq_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_bus_sequencer.sv
// Bench for fpu_bus_sequencer: a small FPU bus model checks every byte access and the
// end_ack handshake against queues filled when each command is issued.
module tb_fpu_bus_sequencer;
    import pa_fpu::*;

    logic            clk = 1'b0;
    logic            arst;
    logic            cmd_valid;
    logic            cmd_ready;
    e_fpu_operations cmd_op;
    logic [31:0]     cmd_a, cmd_b;
    logic            cmd_use_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_result;
    logic            rsp_timeout;
    logic [7:0]      fpu_databus_out;
    logic [7:0]      fpu_databus_in;
    logic [3:0]      fpu_addr;
    logic            fpu_cs, fpu_rd, fpu_wr;
    logic            fpu_end_ack;
    logic            fpu_cmd_end = 1'b0;
    logic            fpu_busy;
    logic            seq_busy;

    typedef struct packed { logic [3:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [31:0] res; logic tmo; } rsp_t;

    wr_t        wr_exp[$];
    logic [3:0] rd_exp[$];
    rsp_t       rsp_exp[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;

    logic [31:0] mdl_result = 32'h0;
    bit          mdl_never  = 1'b0;
    bit          mdl_stale  = 1'b0;
    bit          stale_used = 1'b0;
    int          end_cnt = 0;
    int          ack_cnt = 0;
    bit          ack_seen = 1'b0;
    bit          drop_pend = 1'b0;

    fpu_bus_sequencer #(
        .STROBE_CYCLES (1),
        .TIMEOUT_CYCLES(16),
        .TCW           (16)
    ) dut (
        .clk            (clk),
        .arst           (arst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_use_b      (cmd_use_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_timeout    (rsp_timeout),
        .fpu_databus_out(fpu_databus_out),
        .fpu_databus_in (fpu_databus_in),
        .fpu_addr       (fpu_addr),
        .fpu_cs         (fpu_cs),
        .fpu_rd         (fpu_rd),
        .fpu_wr         (fpu_wr),
        .fpu_end_ack    (fpu_end_ack),
        .fpu_cmd_end    (fpu_cmd_end),
        .fpu_busy       (fpu_busy),
        .seq_busy       (seq_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign fpu_busy = 1'b0;

    always_comb begin
        case (fpu_addr)
            4'h9:    fpu_databus_in = mdl_result[7:0];
            4'hA:    fpu_databus_in = mdl_result[15:8];
            4'hB:    fpu_databus_in = mdl_result[23:16];
            4'hC:    fpu_databus_in = mdl_result[31:24];
            default: fpu_databus_in = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // FPU model and bus/response monitors, all sampled mid-cycle.
    always @(negedge clk) begin
        wr_t  w;
        rsp_t r;
        logic [3:0] ra;
        if (arst) begin
            end_cnt = 0; ack_cnt = 0; ack_seen = 1'b0; drop_pend = 1'b0;
            fpu_cmd_end = 1'b0;
        end else begin
            if (mdl_stale && !stale_used) begin
                fpu_cmd_end = 1'b1;
                stale_used = 1'b1;
            end
            if (!mdl_stale) stale_used = 1'b0;
            chk("rd_wr_both", {31'd0, fpu_rd | fpu_wr}, 32'd1);
            if (!fpu_wr) begin
                chk("wr_cs", fpu_cs, 0);
                if (wr_exp.size() == 0) chk("wr_unexp", fpu_wr, 1);
                else begin
                    w = wr_exp.pop_front();
                    chk("wr_addr", fpu_addr, w.addr);
                    chk("wr_data", fpu_databus_out, w.data);
                    if (fpu_addr == 4'h9) begin
                        start_cyc = cyc;
                        if (!mdl_never) end_cnt = 3;
                    end
                end
            end
            if (!fpu_rd) begin
                chk("rd_cs", fpu_cs, 0);
                if (rd_exp.size() == 0) chk("rd_unexp", fpu_rd, 1);
                else begin
                    ra = rd_exp.pop_front();
                    chk("rd_addr", fpu_addr, ra);
                end
            end
            if (fpu_end_ack) chk("cs_in_ack", fpu_cs, 1);
            if (mdl_never && fpu_end_ack) chk("ack_in_tmo", fpu_end_ack, 0);
            if (end_cnt > 0) begin
                end_cnt--;
                if (end_cnt == 0) fpu_cmd_end = 1'b1;
            end
            if (drop_pend) begin
                chk("ack_fall", fpu_end_ack, 0);
                drop_pend = 1'b0;
                ack_seen = 1'b0;
            end else if (fpu_cmd_end && (ack_seen || fpu_end_ack)) begin
                if (ack_seen) chk("ack_hold", fpu_end_ack, 1);
                ack_seen = 1'b1;
                ack_cnt++;
                if (ack_cnt == 3) begin
                    fpu_cmd_end = 1'b0;
                    drop_pend = 1'b1;
                    ack_cnt = 0;
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_exp.size() == 0) chk("rsp_unexp", rsp_valid, 0);
                else begin
                    r = rsp_exp.pop_front();
                    chk("rsp_result", rsp_result, r.res);
                    chk("rsp_tmo", rsp_timeout, r.tmo);
                    if (r.tmo) chk("tmo_lat", cyc - start_cyc, 18);
                end
            end
        end
    end

    task automatic push_writes(input e_fpu_operations op, input logic [31:0] a,
                               input logic [31:0] b, input logic use_b);
        wr_t w;
        for (int i = 0; i < 4; i++) begin
            w.addr = 4'(i); w.data = a[8*i +: 8]; wr_exp.push_back(w);
        end
        if (use_b) begin
            for (int i = 0; i < 4; i++) begin
                w.addr = 4'(4 + i); w.data = b[8*i +: 8]; wr_exp.push_back(w);
            end
        end
        w.addr = 4'h8; w.data = 8'(op);  wr_exp.push_back(w);
        w.addr = 4'h9; w.data = 8'h00;   wr_exp.push_back(w);
    endtask

    task automatic run_cmd(input e_fpu_operations op, input logic [31:0] a, input logic [31:0] b,
                           input logic use_b, input logic [31:0] res, input logic tmo,
                           input bit stale, input bit bp);
        rsp_t r;
        int n;
        mdl_result = res;
        push_writes(op, a, b, use_b);
        if (!tmo) for (int i = 0; i < 4; i++) rd_exp.push_back(4'(9 + i));
        r.res = tmo ? 32'h0 : res;
        r.tmo = tmo;
        rsp_exp.push_back(r);
        rsp_ready = !bp;
        if (stale) begin
            mdl_stale = 1'b1;
            @(posedge clk); #1;
        end
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_b = use_b;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        mdl_stale = 1'b0;
        chk("rdy_drop", cmd_ready, 0);
        chk("seq_busy", seq_busy, 1);
        n = 0;
        while (!rsp_valid && n < 400) begin @(posedge clk); #1; n++; end
        chk("rsp_wait", rsp_valid, 1);
        if (bp) begin
            for (int i = 0; i < 5; i++) begin
                chk("bp_vld", rsp_valid, 1);
                chk("bp_res", rsp_result, r.res);
                chk("bp_rdy", cmd_ready, 0);
                chk("bp_bus", {29'd0, fpu_cs, fpu_rd, fpu_wr}, 32'd7);
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_rdy_back", cmd_ready, 1);
            chk("bp_vld_drop", rsp_valid, 0);
        end else begin
            @(posedge clk); #1;
            chk("rsp_drop", rsp_valid, 0);
        end
        chk("wr_left", wr_exp.size(), 0);
        chk("rd_left", rd_exp.size(), 0);
        chk("rsp_left", rsp_exp.size(), 0);
        rsp_ready = 1'b1;
    endtask

    initial begin
        int n;
        int k;
        arst = 1'b1; cmd_valid = 1'b0; cmd_op = op_add; cmd_a = 32'h0; cmd_b = 32'h0;
        cmd_use_b = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_bus", {29'd0, fpu_cs, fpu_rd, fpu_wr}, 32'd7);
        chk("rst_ack", fpu_end_ack, 0);
        chk("rst_addr", fpu_addr, 0);
        chk("rst_dout", fpu_databus_out, 0);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_res", rsp_result, 0);
        chk("rst_tmo", rsp_timeout, 0);
        chk("rst_busy", seq_busy, 0);
        arst = 1'b0;
        @(posedge clk); #1;

        run_cmd(op_sqrt, 32'h7f7fffff, 32'h0, 1'b0, 32'h5f7fffff, 1'b0, 1'b0, 1'b0);
        run_cmd(op_div, 32'h3f800000, 32'h3f8ccccd, 1'b1, 32'h3f68ba2f, 1'b0, 1'b0, 1'b0);
        run_cmd(op_mul, 32'h40000000, 32'h40400000, 1'b1, 32'h40c00000, 1'b0, 1'b0, 1'b1);
        mdl_never = 1'b1;
        run_cmd(op_sqrt, 32'h40800000, 32'h0, 1'b0, 32'h40000000, 1'b1, 1'b0, 1'b0);
        mdl_never = 1'b0;
        run_cmd(op_neg, 32'h12345678, 32'h0, 1'b0, 32'h92345678, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of the third write strobe.
        push_writes(op_add, 32'haabbccdd, 32'h11223344, 1'b1);
        cmd_valid = 1'b1; cmd_op = op_add; cmd_a = 32'haabbccdd; cmd_b = 32'h11223344;
        cmd_use_b = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0; k = 0;
        while (n < 3 && k < 100) begin
            @(negedge clk);
            if (!fpu_wr) n++;
            k++;
        end
        chk("third_strobe", n, 3);
        #2;
        arst = 1'b1;
        #1;
        chk("amid_bus", {29'd0, fpu_cs, fpu_rd, fpu_wr}, 32'd7);
        chk("amid_ack", fpu_end_ack, 0);
        chk("amid_rdy", cmd_ready, 1);
        wr_exp.delete(); rd_exp.delete(); rsp_exp.delete();
        @(posedge clk); #1;
        arst = 1'b0;
        chk("post_rst_rdy", cmd_ready, 1);
        chk("post_rst_vld", rsp_valid, 0);
        chk("post_rst_busy", seq_busy, 0);
        @(posedge clk); #1;
        run_cmd(op_add, 32'h3f800000, 32'h40000000, 1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1);
    end

endmodule

// File: doc/fpu_bus_sequencer.md
Name: fpu_bus_sequencer

Overview:
- Upstream master for the byte-wide FPU register port.
- Accepts one 32-bit command (operation, operand A, optional operand B) on a valid/ready interface.
- Runs the full FPU bus protocol: operand and operation writes, start strobe, wait for cmd_end, 4-byte result read, end_ack handshake.
- Returns the 32-bit result on a valid/ready response interface, so the CPU/microcode side never bit-bangs cs/rd/wr.

Parameters:
- STROBE_CYCLES, 1: clocks wr/rd are held low per byte access (≥1).
- TIMEOUT_CYCLES, 65535: max clocks in WAIT_END before abort (≥1).
- TCW, 16: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, shared with the FPU
- arst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  8  pa_fpu::e_fpu_operations code
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_use_b  in  1  1 = write operand B; 0 = unary op, B writes skipped
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_result  out  32  FPU result
- rsp_timeout  out  1  qualifies rsp_valid: cmd_end never arrived
- fpu_databus_out  out  8  to FPU databus_in
- fpu_databus_in  in  8  from FPU databus_out
- fpu_addr  out  4  FPU register address
- fpu_cs  out  1  chip select, active low
- fpu_rd  out  1  read strobe, active low
- fpu_wr  out  1  write strobe, active low
- fpu_end_ack  out  1  end acknowledge, active high
- fpu_cmd_end  in  1  FPU command done, synchronous to clk
- fpu_busy  in  1  FPU busy; status only, not used for sequencing
- seq_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, applied immediately and asynchronously, including mid-operation:
  - fpu_cs, fpu_rd, fpu_wr = 1; fpu_end_ack = 0; fpu_addr = 0; fpu_databus_out = 0.
  - cmd_ready = 1; rsp_valid = 0; rsp_result = 0; rsp_timeout = 0; state = IDLE.
- Command capture: on cmd_valid & cmd_ready, all cmd_* fields are captured into registers; cmd_ready drops the next cycle.
- Byte access, 2+STROBE_CYCLES clocks:
  - SETUP: fpu_cs=0; addr and write data valid; strobe high.
  - STROBE: wr or rd low for STROBE_CYCLES.
  - HOLD: strobe high; addr and data still stable.
  - Read data is sampled on the last STROBE clock.
- fpu_cs stays low across consecutive accesses of one burst. fpu_cs is high for ≥1 clock between bursts.
- Address map:
  - Operand A: 0x0–0x3, LSB first.
  - Operand B: 0x4–0x7, LSB first.
  - Operation: 0x8.
  - Start: write 0x9 (data 0x00).
  - Result: read 0x9, 0xA, 0xB, 0xC = bytes 0..3.
- FSM:
  - IDLE: accept command. If fpu_cmd_end=1 → CLEAR, else → WR_OPS.
  - CLEAR: fpu_end_ack=1 until fpu_cmd_end=0, then end_ack=0 → WR_OPS. This flushes a stale completion.
  - WR_OPS: one burst — A bytes, then B bytes if use_b, then op (0x8), then start (0x9). That is 10 accesses with B, 6 without → WAIT_END.
  - WAIT_END: cs high. Counter increments each clock.
    - fpu_cmd_end=1 → RD_RES.
    - Counter reaches TIMEOUT_CYCLES → RESP with rsp_timeout=1 and rsp_result=0. No read and no end_ack are issued.
  - RD_RES: one 4-access read burst assembling rsp_result → ACK.
  - ACK: fpu_end_ack=1 from the first clock, held until fpu_cmd_end is sampled 0; end_ack deasserts the same clock → RESP.
  - RESP: rsp_valid=1; result and timeout held stable. On rsp_ready → IDLE, rsp_valid=0, cmd_ready=1 the next clock.
- cmd_ready=1 only in IDLE. No command queueing; cmd_valid in other states is ignored.
- fpu_cmd_end rising during WR_OPS means a protocol error; it is ignored until WAIT_END.
- Latency, STROBE_CYCLES=1, fast FPU: unary = 18 (writes) + 1 gap + 12 (reads) clocks, plus FPU compute, ack and response handshakes.

Decomposition:
- pa_fpu additions:
  - Register address constants (FPU_REG_A0..A3, B0..B3, OP, START, RES0..RES3).
  - e_seq_state enum (IDLE, CLEAR, WR_OPS, WAIT_END, RD_RES, ACK, RESP).
- cmd_op is typed as the existing e_fpu_operations.
- One natural sub-module, fpu_bus_access:
  - Single byte-access engine: req/addr/wdata/is_read in; done/rdata out.
  - Owns the SETUP/STROBE/HOLD counter and the rd/wr strobes.
  - A keep_cs input keeps cs low across a burst.
- The top-level FSM sequences addresses and byte indices.

Test Plan:
- Unary sqrt: cmd_a=0x7f7fffff, use_b=0, op=op_sqrt.
  - Expected bus: writes addr 0,1,2,3,8,9 with data ff,ff,7f,7f,op_sqrt,00; then reads 9,A,B,C.
  - FPU model returns 0x5f7fffff → rsp_result=0x5f7fffff, rsp_timeout=0, end_ack high until cmd_end drops.
- Binary: a=0x3f800000, b=0x3f8ccccd, use_b=1, division op.
  - Expected bus: 10 writes at addr 0..9 in order, B bytes cd,cc,8c,3f.
  - Model result 0x3f68ba2f → rsp_result=0x3f68ba2f.
- Backpressure: hold rsp_ready=0 for 5 clocks after rsp_valid → rsp_valid, rsp_result stable, cmd_ready=0, cs/rd/wr high throughout. rsp_ready=1 → cmd_ready=1 next clock.
- Timeout: TIMEOUT_CYCLES=16, model never raises cmd_end → rsp_valid exactly 16 clocks after WAIT_END entry, with rsp_timeout=1, rsp_result=0, no rd strobe, end_ack never asserted.
- Stale completion: fpu_cmd_end=1 at command accept, model drops it 3 clocks after end_ack rises → end_ack high exactly until then; first cs low only afterwards.
- Reset mid-op: assert arst during the third write strobe → cs/wr/rd go high and end_ack low without waiting for clk. After release, cmd_ready=1 and a new command completes normally.
